// File: rtl/apu_freq_counter_pkg.sv
// Shared definitions for the APU frequency counter: default width and FSM state encoding.
package apu_freq_counter_pkg;

  localparam int unsigned APU_FREQ_WIDTH = 11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

endpackage

// File: rtl/apu_freq_counter.sv
// Reloadable up-counter for an APU channel: ticks on overflow and drives the
// load strobe / reload data for the parent's gate-level toggle-cell chain.
module apu_freq_counter
  import apu_freq_counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = APU_FREQ_WIDTH,
  parameter logic [WIDTH-1:0] INIT_CNT = '0
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             trig,
  input  logic             stop,
  input  logic [WIDTH-1:0] freq,
  output logic [WIDTH-1:0] cnt_q,
  output logic             tick,
  output logic             load,
  output logic [WIDTH-1:0] load_d,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] ldat_q, ldat_d;
  logic             tick_q, tick_d;
  logic             load_q, load_nx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ldat_d  = ldat_q;
    tick_d  = 1'b0;
    load_nx = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trig) begin
            cnt_d   = freq;
            ldat_d  = freq;
            load_nx = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (trig) begin
            cnt_d   = freq;
            ldat_d  = freq;
            load_nx = 1'b1;
          end else if (en) begin
            if (cnt_q == MAX) begin
              // Counter parks at MAX; the tick lands in the RELOAD cycle.
              state_d = ST_RELOAD;
              tick_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RELOAD: begin
          cnt_d   = freq;
          ldat_d  = freq;
          load_nx = 1'b1;
          state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= INIT_CNT;
      ldat_q  <= '0;
      tick_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ldat_q  <= ldat_d;
      tick_q  <= tick_d;
      load_q  <= load_nx;
    end
  end

  assign tick    = tick_q;
  assign load    = load_q;
  assign load_d  = ldat_q;
  assign running = (state_q != ST_IDLE);

endmodule
